// File: rtl/adr_decoder_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : adr_decoder_sync_pkg
//  Purpose : Shared definitions for the synchronous bus address decoder:
//            register offsets within the decoded window and FSM encoding.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package adr_decoder_sync_pkg;

  // Register offsets relative to BASE
  localparam logic [1:0] OFS_DATA  = 2'd0;  // read: data strobe, write: reset
  localparam logic [1:0] OFS_LADDR = 2'd1;  // write: low byte of mem_addr
  localparam logic [1:0] OFS_HADDR = 2'd2;  // write: high byte of mem_addr
  localparam logic [1:0] OFS_ROW   = 2'd3;  // write: row strobe

  // Access tracking FSM
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/adr_decoder_sync_sync2.sv
`default_nettype none
// ============================================================================
//  Module  : sync2
//  Purpose : Two-flop synchronizer for active-low bus strobes. Resets to all
//            ones so that a strobe reads as inactive out of reset.
//  Ports   : clk  - system clock
//            rst  - synchronous active-high reset
//            d_i  - asynchronous input
//            q_o  - synchronized output
//  Rev     : 1.0  initial release
// ============================================================================
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/adr_decoder_sync.sv
`default_nettype none
// ============================================================================
//  Module  : adr_decoder_sync
//  Purpose : Decodes an asynchronous bus (active-low csel/rd/wr) into
//            one-clock pulses and a 16-bit memory address register.
//            Window BASE..BASE+3:
//              +0 read  -> rd_pulse, then mem_addr increments
//              +0 write -> res_pulse, mem_addr and err cleared
//              +1 write -> mem_addr low byte  <= din
//              +2 write -> mem_addr high byte <= din
//              +3 write -> row_pulse
//  Ports   : clk, rst               - clock, synchronous active-high reset
//            addr, din              - bus address / write data
//            csel, rd, wr           - active-low async bus strobes
//            rd_pulse, res_pulse,
//            row_pulse              - one-clock registered pulses
//            mem_addr               - memory address register
//            err                    - sticky rd+wr collision flag
//  Rev     : 1.0  initial release
// ============================================================================
module adr_decoder_sync
  import adr_decoder_sync_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int BASE   = 20,
  parameter int MEM_AW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              csel,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  output logic              rd_pulse,
  output logic              res_pulse,
  output logic              row_pulse,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              err
);

  // --------------------------------------------------------------------------
  // Strobe synchronizers
  // --------------------------------------------------------------------------
  logic csel_s;
  logic rd_s;
  logic wr_s;

  sync2 #(.WIDTH(1)) u_sync_csel (.clk(clk), .rst(rst), .d_i(csel), .q_o(csel_s));
  sync2 #(.WIDTH(1)) u_sync_rd   (.clk(clk), .rst(rst), .d_i(rd),   .q_o(rd_s));
  sync2 #(.WIDTH(1)) u_sync_wr   (.clk(clk), .rst(rst), .d_i(wr),   .q_o(wr_s));

  // --------------------------------------------------------------------------
  // Address decode. addr is held stable while a strobe is low, so it is used
  // directly in the cycle the synchronized strobe first shows up.
  // Addresses below BASE wrap to large values and miss the window.
  // --------------------------------------------------------------------------
  logic [31:0] w_rel;
  logic        w_hit;
  logic [1:0]  w_ofs;

  assign w_rel = 32'(addr) - 32'(BASE);
  assign w_hit = (w_rel < 32'd4);
  assign w_ofs = w_rel[1:0];

  logic w_all_idle;
  assign w_all_idle = csel_s & rd_s & wr_s;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e            state_q,     state_d;
  logic [1:0]        settle_q,    settle_d;
  logic              armed_q,     armed_d;
  logic              rd_pulse_q,  rd_pulse_d;
  logic              res_pulse_q, res_pulse_d;
  logic              row_pulse_q, row_pulse_d;
  logic [MEM_AW-1:0] mem_addr_q,  mem_addr_d;
  logic              err_q,       err_d;
  logic              inc_q,       inc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      rd_pulse_q  <= 1'b0;
      res_pulse_q <= 1'b0;
      row_pulse_q <= 1'b0;
      mem_addr_q  <= '0;
      err_q       <= 1'b0;
      inc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      rd_pulse_q  <= rd_pulse_d;
      res_pulse_q <= res_pulse_d;
      row_pulse_q <= row_pulse_d;
      mem_addr_q  <= mem_addr_d;
      err_q       <= err_d;
      inc_q       <= inc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next state / outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rd_pulse_d  = 1'b0;
    res_pulse_d = 1'b0;
    row_pulse_d = 1'b0;
    inc_d       = 1'b0;
    err_d       = err_q;
    // Read of BASE+0 bumps the address one cycle after its pulse.
    mem_addr_d  = inc_q ? (mem_addr_q + MEM_AW'(1)) : mem_addr_q;

    // The synchronizers hold their reset value for two cycles after reset,
    // which would hide a strobe still held low from before reset. settle_q
    // waits out that window; only then can an all-inactive observation arm
    // the decoder, so an access interrupted by reset is never re-decoded.
    settle_d = {settle_q[0], 1'b1};
    armed_d  = armed_q | (settle_q[1] & w_all_idle);

    case (state_q)
      ST_IDLE: begin
        if (armed_q && !csel_s && (!rd_s || !wr_s)) begin
          state_d = ST_ACTIVE;
          if (!rd_s && !wr_s) begin
            err_d = 1'b1;
          end else if (w_hit) begin
            if (!rd_s) begin
              if (w_ofs == OFS_DATA) begin
                rd_pulse_d = 1'b1;
                inc_d      = 1'b1;
              end
            end else begin
              case (w_ofs)
                OFS_DATA: begin
                  res_pulse_d = 1'b1;
                  mem_addr_d  = '0;
                  err_d       = 1'b0;
                end
                OFS_LADDR: mem_addr_d[DATA_W-1:0]      = din;
                OFS_HADDR: mem_addr_d[MEM_AW-1:DATA_W] = din;
                default:   row_pulse_d                 = 1'b1;
              endcase
            end
          end
        end
      end
      default: begin
        if (w_all_idle) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign rd_pulse  = rd_pulse_q;
  assign res_pulse = res_pulse_q;
  assign row_pulse = row_pulse_q;
  assign mem_addr  = mem_addr_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_adr_decoder_sync.sv
`default_nettype none
// ============================================================================
//  Module  : tb_adr_decoder_sync
//  Purpose : Self-checking bench for adr_decoder_sync. Directed scenarios
//            plus random bus accesses checked against a transaction-level
//            model of the register window.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_adr_decoder_sync;

  localparam int BASE = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  addr;
  logic        csel;
  logic        rd;
  logic        wr;
  logic [7:0]  din;
  logic        rd_pulse;
  logic        res_pulse;
  logic        row_pulse;
  logic [15:0] mem_addr;
  logic        err;

  int vectors = 0;
  int errors  = 0;

  // Transaction-level model state
  logic [15:0] m_mem = 16'h0000;
  logic        m_err = 1'b0;

  adr_decoder_sync #(
    .ADDR_W(5), .DATA_W(8), .BASE(BASE), .MEM_AW(16)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .csel(csel), .rd(rd), .wr(wr),
    .din(din), .rd_pulse(rd_pulse), .res_pulse(res_pulse),
    .row_pulse(row_pulse), .mem_addr(mem_addr), .err(err)
  );

  always #5 clk = ~clk;

  // Model: effect of one complete bus access on the register window.
  task automatic model_apply(input logic [4:0] a, input logic [7:0] d,
                             input logic do_rd, input logic do_wr,
                             output int e_rd, output int e_res, output int e_row);
    int rel;
    e_rd = 0; e_res = 0; e_row = 0;
    rel = int'(a) - BASE;
    if (do_rd && do_wr) begin
      m_err = 1'b1;
    end else if (rel >= 0 && rel <= 3) begin
      if (do_rd) begin
        if (rel == 0) begin
          e_rd  = 1;
          m_mem = m_mem + 16'd1;
        end
      end else begin
        if (rel == 0) begin
          e_res = 1; m_mem = 16'h0000; m_err = 1'b0;
        end else if (rel == 1) begin
          m_mem = {m_mem[15:8], d};
        end else if (rel == 2) begin
          m_mem = {d, m_mem[7:0]};
        end else begin
          e_row = 1;
        end
      end
    end
  endtask

  // Drive one access (strobes low for 'hold' cycles) and observe outputs.
  // Cycle k counts falling edges after the strobes were driven low.
  task automatic run_access(input logic [4:0] a, input logic [7:0] d,
                            input logic do_rd, input logic do_wr, input int hold,
                            output int n_rd, output int n_res, output int n_row,
                            output int first_cyc,
                            output logic [15:0] m3, output logic [15:0] m4);
    n_rd = 0; n_res = 0; n_row = 0; first_cyc = -1; m3 = '0; m4 = '0;
    @(negedge clk);
    addr = a; din = d; csel = 1'b0; rd = ~do_rd; wr = ~do_wr;
    for (int k = 1; k <= hold + 8; k++) begin
      @(negedge clk);
      if (rd_pulse)  n_rd++;
      if (res_pulse) n_res++;
      if (row_pulse) n_row++;
      if ((rd_pulse || res_pulse || row_pulse) && first_cyc < 0) first_cyc = k;
      if (k == 3) m3 = mem_addr;
      if (k == 4) m4 = mem_addr;
      if (k == hold) begin
        csel = 1'b1; rd = 1'b1; wr = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; csel = 1'b1; rd = 1'b1; wr = 1'b1; addr = '0; din = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rd_pulse, res_pulse, row_pulse} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got=%b want=000", {rd_pulse, res_pulse, row_pulse});
    end
    vectors++;
    if (mem_addr !== 16'h0000) begin
      errors++; $display("FAIL reset_mem got=%h want=0000", mem_addr);
    end
    vectors++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset_err got=%b want=0", err);
    end
    rst = 1'b0;
    m_mem = 16'h0000; m_err = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_low_write;
    int n_rd, n_res, n_row, fc, e_rd, e_res, e_row;
    logic [15:0] m3, m4;
    run_access(5'd21, 8'h34, 1'b0, 1'b1, 10, n_rd, n_res, n_row, fc, m3, m4);
    model_apply(5'd21, 8'h34, 1'b0, 1'b1, e_rd, e_res, e_row);
    vectors++;
    if (n_rd + n_res + n_row !== 0) begin
      errors++; $display("FAIL lowwr_pulses got=%0d want=0", n_rd + n_res + n_row);
    end
    vectors++;
    if (m3[7:0] !== 8'h34) begin
      errors++; $display("FAIL lowwr_cycle3 got=%h want=34", m3[7:0]);
    end
    vectors++;
    if (mem_addr !== m_mem) begin
      errors++; $display("FAIL lowwr_mem got=%h want=%h", mem_addr, m_mem);
    end
  endtask

  task automatic test_read_incr;
    int n_rd, n_res, n_row, fc, e_rd, e_res, e_row, tot_rd;
    logic [15:0] m3, m4;
    run_access(5'd22, 8'h12, 1'b0, 1'b1, 4, n_rd, n_res, n_row, fc, m3, m4);
    model_apply(5'd22, 8'h12, 1'b0, 1'b1, e_rd, e_res, e_row);
    run_access(5'd21, 8'hFF, 1'b0, 1'b1, 4, n_rd, n_res, n_row, fc, m3, m4);
    model_apply(5'd21, 8'hFF, 1'b0, 1'b1, e_rd, e_res, e_row);
    tot_rd = 0;
    for (int i = 0; i < 3; i++) begin
      run_access(5'd20, 8'h00, 1'b1, 1'b0, 2 + i, n_rd, n_res, n_row, fc, m3, m4);
      model_apply(5'd20, 8'h00, 1'b1, 1'b0, e_rd, e_res, e_row);
      tot_rd += n_rd;
      vectors++;
      if (fc !== 3) begin
        errors++; $display("FAIL rd_latency got=%0d want=3", fc);
      end
      vectors++;
      if (m4 !== m_mem || m3 !== m_mem - 16'd1) begin
        errors++; $display("FAIL rd_incr_timing got=%h/%h want=%h/%h", m3, m4, m_mem - 16'd1, m_mem);
      end
    end
    vectors++;
    if (tot_rd !== 3) begin
      errors++; $display("FAIL rd_count got=%0d want=3", tot_rd);
    end
    vectors++;
    if (mem_addr !== 16'h1302) begin
      errors++; $display("FAIL rd_mem got=%h want=1302", mem_addr);
    end
  endtask

  task automatic test_wrap;
    int n_rd, n_res, n_row, fc, e_rd, e_res, e_row;
    logic [15:0] m3, m4;
    run_access(5'd21, 8'hFF, 1'b0, 1'b1, 3, n_rd, n_res, n_row, fc, m3, m4);
    model_apply(5'd21, 8'hFF, 1'b0, 1'b1, e_rd, e_res, e_row);
    run_access(5'd22, 8'hFF, 1'b0, 1'b1, 3, n_rd, n_res, n_row, fc, m3, m4);
    model_apply(5'd22, 8'hFF, 1'b0, 1'b1, e_rd, e_res, e_row);
    vectors++;
    if (mem_addr !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_pre got=%h want=ffff", mem_addr);
    end
    run_access(5'd20, 8'h00, 1'b1, 1'b0, 3, n_rd, n_res, n_row, fc, m3, m4);
    model_apply(5'd20, 8'h00, 1'b1, 1'b0, e_rd, e_res, e_row);
    vectors++;
    if (mem_addr !== 16'h0000) begin
      errors++; $display("FAIL wrap_post got=%h want=0000", mem_addr);
    end
  endtask

  task automatic test_collision;
    int n_rd, n_res, n_row, fc, e_rd, e_res, e_row;
    logic [15:0] m3, m4;
    run_access(5'd22, 8'h5A, 1'b0, 1'b1, 3, n_rd, n_res, n_row, fc, m3, m4);
    model_apply(5'd22, 8'h5A, 1'b0, 1'b1, e_rd, e_res, e_row);
    run_access(5'd20, 8'h00, 1'b1, 1'b1, 5, n_rd, n_res, n_row, fc, m3, m4);
    model_apply(5'd20, 8'h00, 1'b1, 1'b1, e_rd, e_res, e_row);
    vectors++;
    if (n_rd + n_res + n_row !== 0) begin
      errors++; $display("FAIL coll_pulses got=%0d want=0", n_rd + n_res + n_row);
    end
    vectors++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL coll_err got=%b want=1", err);
    end
    run_access(5'd20, 8'h00, 1'b0, 1'b1, 5, n_rd, n_res, n_row, fc, m3, m4);
    model_apply(5'd20, 8'h00, 1'b0, 1'b1, e_rd, e_res, e_row);
    vectors++;
    if (n_res !== 1 || fc !== 3) begin
      errors++; $display("FAIL res_pulse got=%0d@%0d want=1@3", n_res, fc);
    end
    vectors++;
    if (err !== 1'b0 || mem_addr !== 16'h0000) begin
      errors++; $display("FAIL res_clear got=%b/%h want=0/0000", err, mem_addr);
    end
  endtask

  task automatic test_row_hold;
    int n_rd, n_res, n_row, fc, e_rd, e_res, e_row;
    logic [15:0] m3, m4;
    run_access(5'd23, 8'h77, 1'b0, 1'b1, 50, n_rd, n_res, n_row, fc, m3, m4);
    model_apply(5'd23, 8'h77, 1'b0, 1'b1, e_rd, e_res, e_row);
    vectors++;
    if (n_row !== 1 || fc !== 3) begin
      errors++; $display("FAIL row_hold got=%0d@%0d want=1@3", n_row, fc);
    end
    run_access(5'd25, 8'h77, 1'b0, 1'b1, 5, n_rd, n_res, n_row, fc, m3, m4);
    model_apply(5'd25, 8'h77, 1'b0, 1'b1, e_rd, e_res, e_row);
    vectors++;
    if (n_rd + n_res + n_row !== 0 || mem_addr !== m_mem) begin
      errors++; $display("FAIL out_of_window got=%0d/%h want=0/%h", n_rd + n_res + n_row, mem_addr, m_mem);
    end
  endtask

  task automatic test_reset_mid_access;
    int n_row, bad, n_rd, n_res, fc, e_rd, e_res, e_row;
    logic [15:0] m3, m4;
    // Put something in mem_addr first so the reset-to-zero is visible.
    run_access(5'd21, 8'hA5, 1'b0, 1'b1, 3, n_rd, n_res, n_row, fc, m3, m4);
    model_apply(5'd21, 8'hA5, 1'b0, 1'b1, e_rd, e_res, e_row);
    n_row = 0; bad = 0;
    @(negedge clk);
    addr = 5'd23; din = 8'h00; csel = 1'b0; wr = 1'b0; rd = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) rst = 1'b1;
      if (k == 2) rst = 1'b0;
      if (row_pulse) n_row++;
      if (k >= 2 && (rd_pulse || res_pulse || row_pulse || mem_addr !== 16'h0000 || err !== 1'b0)) bad++;
    end
    m_mem = 16'h0000; m_err = 1'b0;
    vectors++;
    if (n_row !== 0) begin
      errors++; $display("FAIL rst_mid_row got=%0d want=0", n_row);
    end
    vectors++;
    if (bad !== 0) begin
      errors++; $display("FAIL rst_mid_outputs got=%0d nonzero cycles want=0", bad);
    end
    csel = 1'b1; wr = 1'b1;
    repeat (6) @(negedge clk);
    run_access(5'd23, 8'h00, 1'b0, 1'b1, 4, n_rd, n_res, n_row, fc, m3, m4);
    model_apply(5'd23, 8'h00, 1'b0, 1'b1, e_rd, e_res, e_row);
    vectors++;
    if (n_row !== 1 || fc !== 3) begin
      errors++; $display("FAIL rst_rearm got=%0d@%0d want=1@3", n_row, fc);
    end
  endtask

  task automatic test_random;
    int n_rd, n_res, n_row, fc, e_rd, e_res, e_row, hold, sel;
    logic [15:0] m3, m4, old_mem;
    logic [4:0]  a;
    logic [7:0]  d;
    logic        r, w;
    for (int t = 0; t < 60; t++) begin
      a    = 5'($urandom_range(17, 26));
      d    = 8'($urandom);
      hold = int'($urandom_range(1, 8));
      sel  = int'($urandom_range(0, 9));
      r    = (sel < 4) || (sel == 9);
      w    = (sel >= 4);
      old_mem = m_mem;
      run_access(a, d, r, w, hold, n_rd, n_res, n_row, fc, m3, m4);
      model_apply(a, d, r, w, e_rd, e_res, e_row);
      vectors++;
      if (n_rd !== e_rd || n_res !== e_res || n_row !== e_row) begin
        errors++;
        $display("FAIL rnd_pulses a=%0d r=%b w=%b got=%0d%0d%0d want=%0d%0d%0d",
                 a, r, w, n_rd, n_res, n_row, e_rd, e_res, e_row);
      end
      vectors++;
      if (fc !== ((e_rd + e_res + e_row) > 0 ? 3 : -1)) begin
        errors++; $display("FAIL rnd_latency a=%0d got=%0d", a, fc);
      end
      vectors++;
      if (e_rd == 1 ? (m3 !== old_mem || m4 !== m_mem) : (m3 !== m_mem)) begin
        errors++; $display("FAIL rnd_mem_timing a=%0d got=%h/%h want=%h", a, m3, m4, m_mem);
      end
      vectors++;
      if (mem_addr !== m_mem || err !== m_err) begin
        errors++; $display("FAIL rnd_state a=%0d got=%h/%b want=%h/%b", a, mem_addr, err, m_mem, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_low_write();
    test_read_incr();
    test_wrap();
    test_collision();
    test_row_hold();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
